// File: rtl/alu_issue_ctrl_if.sv
// Decode-to-issue handshake: one decoded add/addi op per valid/ready transfer.
interface alu_issue_ctrl_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
);
  logic            dec_valid;
  logic            dec_ready;
  logic            dec_add;
  logic            dec_addi;
  logic [RA_W-1:0] dec_rs1;
  logic [RA_W-1:0] dec_rs2;
  logic [RA_W-1:0] dec_rd;
  logic [XLEN-1:0] dec_imm;

  // Decode stage drives the op and waits for ready
  modport master (
    output dec_valid, dec_add, dec_addi, dec_rs1, dec_rs2, dec_rd, dec_imm,
    input  dec_ready
  );

  // Issue controller consumes the op and owns ready
  modport slave (
    input  dec_valid, dec_add, dec_addi, dec_rs1, dec_rs2, dec_rd, dec_imm,
    output dec_ready
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue scheduler between decode and a single-cycle alu: operand read with
// forwarding from the completing alu op, RAW stall against the op in issue,
// flush kill, and pass-through write-back.
module alu_issue_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  alu_issue_ctrl_if.slave      dec,
  output logic [RA_W-1:0]      rf_rs1_addr,
  output logic [RA_W-1:0]      rf_rs2_addr,
  input  logic [XLEN-1:0]      rf_rs1_data,
  input  logic [XLEN-1:0]      rf_rs2_data,
  output logic [XLEN-1:0]      alu_src1_value,
  output logic [XLEN-1:0]      alu_src2_value,
  output logic [RA_W-1:0]      alu_src1_addr,
  output logic [RA_W-1:0]      alu_src2_addr,
  output logic [XLEN-1:0]      alu_imm,
  output logic [RA_W-1:0]      alu_rd,
  output logic                 alu_add,
  output logic                 alu_addi,
  output logic                 alu_jump_branch_enable,
  input  logic                 alu_done,
  input  logic [RA_W-1:0]      alu_write_addr,
  input  logic [XLEN-1:0]      alu_result,
  output logic                 wb_we,
  output logic [RA_W-1:0]      wb_addr,
  output logic [XLEN-1:0]      wb_data,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t          state;
  logic            iss_vld;
  logic            hazard;
  logic            take;
  logic            rs1_fwd;
  logic            rs2_fwd;
  logic [XLEN-1:0] src1_sel;
  logic [XLEN-1:0] src2_sel;

  // Regfile read ports follow decode directly
  assign rf_rs1_addr = dec.dec_rs1;
  assign rf_rs2_addr = dec.dec_rs2;

  // Write-back is the completing alu result; x0 writes are dropped
  assign wb_we   = alu_done & (alu_write_addr != '0);
  assign wb_addr = alu_write_addr;
  assign wb_data = alu_result;

  // RAW check against the op currently held in the issue registers
  always_comb begin
    iss_vld = alu_add | alu_addi;
    hazard  = dec.dec_valid & iss_vld & (alu_rd != '0) &
              ((alu_rd == dec.dec_rs1) | (dec.dec_add & (alu_rd == dec.dec_rs2)));
  end

  // Ready only in RUN with no flush and no hazard; forced low during reset
  assign dec.dec_ready = reset_n & (state == ST_RUN) & ~flush & ~hazard;
  assign take          = dec.dec_valid & dec.dec_ready & (dec.dec_add | dec.dec_addi);

  // Operand select: x0 reads zero, then forward from the completing op, then regfile
  always_comb begin
    rs1_fwd  = alu_done & (alu_write_addr == dec.dec_rs1);
    rs2_fwd  = alu_done & (alu_write_addr == dec.dec_rs2);
    src1_sel = rf_rs1_data;
    src2_sel = rf_rs2_data;
    if (dec.dec_rs1 == '0) begin
      src1_sel = '0;
    end else if (rs1_fwd) begin
      src1_sel = alu_result;
    end
    if (dec.dec_rs2 == '0) begin
      src2_sel = '0;
    end else if (rs2_fwd) begin
      src2_sel = alu_result;
    end
    if (dec.dec_addi) begin
      src2_sel = '0;
    end
  end

  // Control FSM, issue registers and stall counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= ST_RUN;
      alu_src1_value         <= '0;
      alu_src2_value         <= '0;
      alu_src1_addr          <= '0;
      alu_src2_addr          <= '0;
      alu_imm                <= '0;
      alu_rd                 <= '0;
      alu_add                <= 1'b0;
      alu_addi               <= 1'b0;
      alu_jump_branch_enable <= 1'b0;
      stall_cnt              <= '0;
    end else begin
      alu_jump_branch_enable <= flush;
      alu_add                <= 1'b0;
      alu_addi               <= 1'b0;
      if (flush) begin
        state          <= ST_FLUSH;
        alu_src1_value <= '0;
        alu_src2_value <= '0;
        alu_src1_addr  <= '0;
        alu_src2_addr  <= '0;
        alu_imm        <= '0;
        alu_rd         <= '0;
      end else begin
        case (state)
          ST_RUN: begin
            if (hazard) begin
              state <= ST_STALL;
              if (stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
              end
            end else if (take) begin
              alu_add        <= dec.dec_add;
              alu_addi       <= dec.dec_addi;
              alu_src1_value <= src1_sel;
              alu_src2_value <= src2_sel;
              alu_src1_addr  <= dec.dec_rs1;
              alu_src2_addr  <= dec.dec_addi ? '0 : dec.dec_rs2;
              alu_imm        <= dec.dec_imm;
              alu_rd         <= dec.dec_rd;
            end
          end
          default: begin
            state <= ST_RUN;
          end
        endcase
      end
    end
  end

endmodule
